uart_tx_stream: RTL

- Synthesizable UART transmitter fed by a byte stream from the filter/readout path (e.g. the processed-image dump logic).
- Drives the SoC serial output pin that the bench's UART monitor decodes into imgOut text.
- Buffers bytes in an internal FIFO and serializes each as 8N1: one start bit, 8 data bits LSB first, one stop bit.
- Uses a valid/ready input handshake so no byte is ever dropped.

---
 rtl/uart_tx_stream.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_stream.sv
// Byte-stream UART transmitter: a small FIFO in front of an 8N1 serializer.
// The input handshake is valid/ready, so bytes queue instead of dropping.
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  input  logic [7:0]                    s_data,
  output logic                          s_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic             push, pop, bit_end;

  always_comb begin
    push    = s_valid && ready_q;
    bit_end = (cnt_q == LAST_C);
    pop     = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          cnt_d   = '0;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          txd_d   = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit so bursts have no idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop  ? rd_q + AW'(1) : rd_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != DEPTH_C);
    busy_d  = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Storage needs no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s_data;
  end

  assign s_ready    = ready_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule
